// File: rtl/map_writer.sv
// Write master for the voxel map RAM: fills 32x32x32 terrain, then applies place/break edits.
// Latency: an accepted command shows its write (or cmd_err) in the next cycle; the fill writes one address per cycle.
// Backpressure: cmd_ready is low during the fill and whenever regen is high; in IDLE a command is accepted every cycle.
module map_writer #(
   parameter int STONE_TOP = 20,
   parameter int DIRT_TOP  = 23,
   parameter int GRASS_Y   = 24,
   parameter int MAX_ID    = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        regen,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [4:0]  cmd_x,
   input  logic [4:0]  cmd_y,
   input  logic [4:0]  cmd_z,
   input  logic        cmd_place,
   input  logic [4:0]  cmd_id,
   output logic        cmd_err,
   output logic [14:0] write_addr,
   output logic [4:0]  write_data,
   output logic        write_en,
   output logic        init_done,
   output logic [15:0] edit_count
);

   localparam logic [0:0] ST_FILL = 1'b0;
   localparam logic [0:0] ST_IDLE = 1'b1;

   localparam logic [4:0] ID_AIR     = 5'd0;
   localparam logic [4:0] ID_BEDROCK = 5'd1;
   localparam logic [4:0] ID_STONE   = 5'd2;
   localparam logic [4:0] ID_DIRT    = 5'd3;
   localparam logic [4:0] ID_GRASS   = 5'd4;

   // Layered terrain: bedrock floor, stone, dirt, one grass layer, air above.
   function automatic logic [4:0] terrain_id(input logic [4:0] y);
      logic [4:0] id;
      if (y == 5'd0)                    id = ID_BEDROCK;
      else if (y <= 5'(STONE_TOP))      id = ID_STONE;
      else if (y <= 5'(DIRT_TOP))       id = ID_DIRT;
      else if (y == 5'(GRASS_Y))        id = ID_GRASS;
      else                              id = ID_AIR;
      return id;
   endfunction

   logic [0:0]  state_q, state_d;
   // Bit 15 set means the sweep has written all 32768 addresses.
   logic [15:0] fc_q, fc_d;
   logic [14:0] write_addr_q, write_addr_d;
   logic [4:0]  write_data_q, write_data_d;
   logic        write_en_q, write_en_d;
   logic        cmd_err_q, cmd_err_d;
   logic        init_done_q, init_done_d;
   logic [15:0] edit_count_q, edit_count_d;

   logic        cmd_fire;
   logic        cmd_reject;

   // regen wins over a simultaneous command by dropping ready for that cycle.
   assign cmd_ready  = (state_q == ST_IDLE) & ~regen;
   assign cmd_fire   = cmd_valid & cmd_ready;
   // Breaking the bedrock floor and out-of-range ids are refused without a write.
   assign cmd_reject = cmd_place ? (cmd_id > 5'(MAX_ID)) : (cmd_y == 5'd0);

   // Next-state: fill sweep, regen restart and edit command handling.
   always_comb begin
      state_d      = state_q;
      fc_d         = fc_q;
      write_en_d   = 1'b0;
      write_addr_d = 15'd0;
      write_data_d = 5'd0;
      cmd_err_d    = 1'b0;
      init_done_d  = init_done_q;
      edit_count_d = edit_count_q;

      case (state_q)
         ST_FILL: begin
            init_done_d = 1'b0;
            if (regen) begin
               // Restart in place: address 0 is written this cycle, no gap.
               write_en_d   = 1'b1;
               write_addr_d = 15'd0;
               write_data_d = terrain_id(5'd0);
               fc_d         = 16'd1;
            end else if (fc_q[15]) begin
               state_d     = ST_IDLE;
               init_done_d = 1'b1;
            end else begin
               write_en_d   = 1'b1;
               write_addr_d = fc_q[14:0];
               write_data_d = terrain_id(fc_q[14:10]);
               fc_d         = fc_q + 16'd1;
            end
         end
         ST_IDLE: begin
            if (regen) begin
               state_d     = ST_FILL;
               fc_d        = 16'd0;
               init_done_d = 1'b0;
            end else if (cmd_fire) begin
               if (cmd_reject) begin
                  cmd_err_d = 1'b1;
               end else begin
                  write_en_d   = 1'b1;
                  write_addr_d = {cmd_y, cmd_z, cmd_x};
                  write_data_d = cmd_place ? cmd_id : ID_AIR;
                  if (edit_count_q != 16'hFFFF) begin
                     edit_count_d = edit_count_q + 16'd1;
                  end
               end
            end
         end
         default: begin
            state_d = ST_FILL;
            fc_d    = 16'd0;
         end
      endcase
   end

   // State and registered outputs; reset aborts any fill or pending write.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_FILL;
         fc_q         <= 16'd0;
         write_en_q   <= 1'b0;
         write_addr_q <= 15'd0;
         write_data_q <= 5'd0;
         cmd_err_q    <= 1'b0;
         init_done_q  <= 1'b0;
         edit_count_q <= 16'd0;
      end else begin
         state_q      <= state_d;
         fc_q         <= fc_d;
         write_en_q   <= write_en_d;
         write_addr_q <= write_addr_d;
         write_data_q <= write_data_d;
         cmd_err_q    <= cmd_err_d;
         init_done_q  <= init_done_d;
         edit_count_q <= edit_count_d;
      end
   end

   assign write_en   = write_en_q;
   assign write_addr = write_addr_q;
   assign write_data = write_data_q;
   assign cmd_err    = cmd_err_q;
   assign init_done  = init_done_q;
   assign edit_count = edit_count_q;

endmodule

// File: tb/tb_map_writer.sv
// Directed bench for map_writer: fill sweep, regen, edits, rejections, saturation, reset.
// Inputs are driven and outputs sampled on the falling clock edge.
// Expected values are hand-computed constants.
module tb_map_writer;

   logic        clk;
   logic        rst;
   logic        regen;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [4:0]  cmd_x;
   logic [4:0]  cmd_y;
   logic [4:0]  cmd_z;
   logic        cmd_place;
   logic [4:0]  cmd_id;
   logic        cmd_err;
   logic [14:0] write_addr;
   logic [4:0]  write_data;
   logic        write_en;
   logic        init_done;
   logic [15:0] edit_count;

   int n_cmp = 0;
   int n_bad = 0;

   map_writer dut (
      .clk        (clk),
      .rst        (rst),
      .regen      (regen),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_x      (cmd_x),
      .cmd_y      (cmd_y),
      .cmd_z      (cmd_z),
      .cmd_place  (cmd_place),
      .cmd_id     (cmd_id),
      .cmd_err    (cmd_err),
      .write_addr (write_addr),
      .write_data (write_data),
      .write_en   (write_en),
      .init_done  (init_done),
      .edit_count (edit_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One-cycle command; returns at the falling edge where its result is visible.
   task automatic send(input logic [4:0] x, input logic [4:0] y, input logic [4:0] z,
                       input logic place, input logic [4:0] id);
      cmd_x = x; cmd_y = y; cmd_z = z; cmd_place = place; cmd_id = id;
      cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   initial begin
      int bad;
      int side_bad;
      int n_wr;
      logic [4:0] d_y0, d_y1, d_y20, d_y21, d_y23, d_y24, d_y25, d_last;
      logic       init_at_last;

      rst = 1'b1; regen = 1'b0; cmd_valid = 1'b0;
      cmd_x = 5'd0; cmd_y = 5'd0; cmd_z = 5'd0; cmd_place = 1'b0; cmd_id = 5'd0;
      d_y0 = 5'd0; d_y1 = 5'd0; d_y20 = 5'd0; d_y21 = 5'd0;
      d_y23 = 5'd0; d_y24 = 5'd0; d_y25 = 5'd0; d_last = 5'd0; init_at_last = 1'b1;
      repeat (3) @(negedge clk);

      // Reset state
      chk("rst_we",    32'(write_en),   32'd0);
      chk("rst_addr",  32'(write_addr), 32'd0);
      chk("rst_data",  32'(write_data), 32'd0);
      chk("rst_err",   32'(cmd_err),    32'd0);
      chk("rst_init",  32'(init_done),  32'd0);
      chk("rst_cnt",   32'(edit_count), 32'd0);
      chk("rst_ready", 32'(cmd_ready),  32'd0);

      // Fill starts the first cycle after reset release
      rst = 1'b0;
      @(negedge clk);
      chk("fill0_we",   32'(write_en),   32'd1);
      chk("fill0_addr", 32'(write_addr), 32'd0);
      chk("fill0_data", 32'(write_data), 32'd1);
      bad = 0;
      for (int i = 1; i <= 1000; i++) begin
         @(negedge clk);
         if (write_en !== 1'b1 || write_addr !== 15'(i) || cmd_ready !== 1'b0) bad++;
      end
      chk("prefill_seq", 32'(bad), 32'd0);

      // regen while address 1000 is on the port: next write is address 0
      regen = 1'b1;
      #1;
      chk("regen_fill_ready", 32'(cmd_ready), 32'd0);
      @(negedge clk);
      regen = 1'b0;

      bad = 0; side_bad = 0; n_wr = 0;
      for (int i = 0; i < 32768; i++) begin
         if (i > 0) @(negedge clk);
         if (write_en !== 1'b1 || write_addr !== 15'(i)) bad++;
         if (cmd_ready !== 1'b0 || cmd_err !== 1'b0) side_bad++;
         if (i < 32767 && init_done !== 1'b0) side_bad++;
         if (write_en === 1'b1) n_wr++;
         if (i == 0)      d_y0  = write_data;
         if (i == 16'h0400) d_y1  = write_data;
         if (i == 16'h5000) d_y20 = write_data;
         if (i == 16'h5400) d_y21 = write_data;
         if (i == 16'h5C00) d_y23 = write_data;
         if (i == 16'h6000) d_y24 = write_data;
         if (i == 16'h6400) d_y25 = write_data;
         if (i == 32767) begin
            d_last = write_data;
            init_at_last = init_done;
         end
      end
      chk("fill_addr_seq",  32'(bad),      32'd0);
      chk("fill_side_sigs", 32'(side_bad), 32'd0);
      chk("fill_count",     32'(n_wr),     32'd32768);
      chk("data_y0",  32'(d_y0),  32'd1);
      chk("data_y1",  32'(d_y1),  32'd2);
      chk("data_y20", 32'(d_y20), 32'd2);
      chk("data_y21", 32'(d_y21), 32'd3);
      chk("data_y23", 32'(d_y23), 32'd3);
      chk("data_y24", 32'(d_y24), 32'd4);
      chk("data_y25", 32'(d_y25), 32'd0);
      chk("data_last", 32'(d_last), 32'd0);
      chk("init_at_last", 32'(init_at_last), 32'd0);

      @(negedge clk);
      chk("done_we",    32'(write_en),  32'd0);
      chk("done_init",  32'(init_done), 32'd1);
      chk("done_ready", 32'(cmd_ready), 32'd1);
      @(negedge clk);
      chk("idle_we", 32'(write_en), 32'd0);

      // Place then break at x=3 y=30 z=7
      send(5'd3, 5'd30, 5'd7, 1'b1, 5'd9);
      chk("place_we",   32'(write_en),   32'd1);
      chk("place_addr", 32'(write_addr), 32'h78E3);
      chk("place_data", 32'(write_data), 32'd9);
      chk("place_err",  32'(cmd_err),    32'd0);
      chk("place_cnt",  32'(edit_count), 32'd1);
      @(negedge clk);
      chk("place_oneshot", 32'(write_en), 32'd0);
      send(5'd3, 5'd30, 5'd7, 1'b0, 5'd9);
      chk("break_we",   32'(write_en),   32'd1);
      chk("break_addr", 32'(write_addr), 32'h78E3);
      chk("break_data", 32'(write_data), 32'd0);
      chk("break_cnt",  32'(edit_count), 32'd2);

      // Rejections
      send(5'd5, 5'd0, 5'd5, 1'b0, 5'd0);
      chk("brk_y0_we",  32'(write_en),   32'd0);
      chk("brk_y0_err", 32'(cmd_err),    32'd1);
      chk("brk_y0_cnt", 32'(edit_count), 32'd2);
      @(negedge clk);
      chk("err_oneshot", 32'(cmd_err), 32'd0);
      send(5'd1, 5'd10, 5'd2, 1'b1, 5'd20);
      chk("bad_id_we",  32'(write_en),   32'd0);
      chk("bad_id_err", 32'(cmd_err),    32'd1);
      chk("bad_id_cnt", 32'(edit_count), 32'd2);

      // Legal edge cases: place at y=0, place id 0, place MAX_ID
      send(5'd4, 5'd0, 5'd6, 1'b1, 5'd1);
      chk("y0_place_we",   32'(write_en),   32'd1);
      chk("y0_place_err",  32'(cmd_err),    32'd0);
      chk("y0_place_addr", 32'(write_addr), 32'h00C4);
      chk("y0_place_data", 32'(write_data), 32'd1);
      chk("y0_place_cnt",  32'(edit_count), 32'd3);
      send(5'd2, 5'd5, 5'd9, 1'b1, 5'd0);
      chk("id0_we",   32'(write_en),   32'd1);
      chk("id0_addr", 32'(write_addr), 32'h1522);
      chk("id0_data", 32'(write_data), 32'd0);
      chk("id0_cnt",  32'(edit_count), 32'd4);
      send(5'd31, 5'd31, 5'd31, 1'b1, 5'd15);
      chk("max_id_we",   32'(write_en),   32'd1);
      chk("max_id_addr", 32'(write_addr), 32'h7FFF);
      chk("max_id_data", 32'(write_data), 32'd15);
      chk("max_id_cnt",  32'(edit_count), 32'd5);

      // Three back-to-back commands with cmd_valid held
      cmd_x = 5'd1; cmd_y = 5'd2; cmd_z = 5'd3; cmd_place = 1'b1; cmd_id = 5'd7;
      cmd_valid = 1'b1;
      @(negedge clk);
      chk("b2b_a_we",   32'(write_en),   32'd1);
      chk("b2b_a_addr", 32'(write_addr), 32'h0861);
      chk("b2b_a_data", 32'(write_data), 32'd7);
      chk("b2b_a_rdy",  32'(cmd_ready),  32'd1);
      cmd_x = 5'd0; cmd_y = 5'd31; cmd_z = 5'd0; cmd_place = 1'b0; cmd_id = 5'd3;
      @(negedge clk);
      chk("b2b_b_we",   32'(write_en),   32'd1);
      chk("b2b_b_addr", 32'(write_addr), 32'h7C00);
      chk("b2b_b_data", 32'(write_data), 32'd0);
      cmd_x = 5'd31; cmd_y = 5'd1; cmd_z = 5'd31; cmd_place = 1'b1; cmd_id = 5'd12;
      @(negedge clk);
      chk("b2b_c_we",   32'(write_en),   32'd1);
      chk("b2b_c_addr", 32'(write_addr), 32'h07FF);
      chk("b2b_c_data", 32'(write_data), 32'd12);
      chk("b2b_c_cnt",  32'(edit_count), 32'd8);
      cmd_valid = 1'b0;
      @(negedge clk);
      chk("b2b_end_we", 32'(write_en), 32'd0);

      // Saturation: preload the counter near the top
      force dut.edit_count_q = 16'hFFFD;
      #1;
      release dut.edit_count_q;
      send(5'd0, 5'd3, 5'd0, 1'b1, 5'd2);
      chk("sat_fffe", 32'(edit_count), 32'hFFFE);
      send(5'd1, 5'd3, 5'd0, 1'b1, 5'd2);
      chk("sat_ffff", 32'(edit_count), 32'hFFFF);
      send(5'd2, 5'd3, 5'd0, 1'b1, 5'd2);
      chk("sat_hold_we",  32'(write_en),   32'd1);
      chk("sat_hold_cnt", 32'(edit_count), 32'hFFFF);

      // regen together with a command in IDLE
      cmd_x = 5'd3; cmd_y = 5'd9; cmd_z = 5'd9; cmd_place = 1'b1; cmd_id = 5'd5;
      cmd_valid = 1'b1;
      regen = 1'b1;
      #1;
      chk("regen_idle_ready", 32'(cmd_ready), 32'd0);
      @(negedge clk);
      regen = 1'b0;
      cmd_valid = 1'b0;
      chk("regen_idle_we",   32'(write_en),   32'd0);
      chk("regen_idle_err",  32'(cmd_err),    32'd0);
      chk("regen_idle_init", 32'(init_done),  32'd0);
      chk("regen_idle_cnt",  32'(edit_count), 32'hFFFF);
      chk("regen_idle_rdy2", 32'(cmd_ready),  32'd0);
      @(negedge clk);
      chk("refill0_we",   32'(write_en),   32'd1);
      chk("refill0_addr", 32'(write_addr), 32'd0);
      chk("refill0_data", 32'(write_data), 32'd1);
      @(negedge clk);
      chk("refill1_addr", 32'(write_addr), 32'd1);
      repeat (20) @(negedge clk);

      // Reset mid-fill with a saturated counter
      rst = 1'b1;
      @(negedge clk);
      chk("mrst_we",    32'(write_en),   32'd0);
      chk("mrst_addr",  32'(write_addr), 32'd0);
      chk("mrst_data",  32'(write_data), 32'd0);
      chk("mrst_err",   32'(cmd_err),    32'd0);
      chk("mrst_init",  32'(init_done),  32'd0);
      chk("mrst_cnt",   32'(edit_count), 32'd0);
      chk("mrst_ready", 32'(cmd_ready),  32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_we",   32'(write_en),   32'd1);
      chk("post_rst_addr", 32'(write_addr), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/map_writer.md
Name: map_writer

Overview:
- Write-side master for the voxel map RAM port (write_addr/write_data/write_en).
- After reset or a regen request, sweeps the whole 32x32x32 map and fills it with layered terrain.
- Then serves player place/break edit commands over a valid/ready handshake, one map write per accepted command.
- Sits between the game-logic/player controller and the map storage block's write port.

Parameters:
- STONE_TOP, 20, highest y filled with stone (y = 1..STONE_TOP).
- DIRT_TOP, 23, highest y filled with dirt (y = STONE_TOP+1..DIRT_TOP).
- GRASS_Y, 24, single grass layer; y > GRASS_Y is air.
- MAX_ID, 15, largest legal block id for place commands.
- Fixed ids (not parameters): air 0, bedrock 1, stone 2, dirt 3, grass 4.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- regen  in  1  one-cycle pulse: restart the terrain fill.
- cmd_valid  in  1  edit command valid.
- cmd_ready  out  1  edit command accepted when cmd_valid & cmd_ready.
- cmd_x  in  5  block x.
- cmd_y  in  5  block y (vertical).
- cmd_z  in  5  block z.
- cmd_place  in  1  1 = place cmd_id, 0 = break (write air).
- cmd_id  in  5  block id to place.
- cmd_err  out  1  one-cycle pulse: accepted command rejected, no write.
- write_addr  out  15  map address {y, z, x}.
- write_data  out  5  block id written.
- write_en  out  1  write strobe, one write per cycle.
- init_done  out  1  high once the fill completes; low during any fill.
- edit_count  out  16  number of successful edit writes, saturating.

Behaviour:
- Reset values: all outputs 0 and state = FILL with fill counter 0.
- Reset mid-fill or mid-command aborts the operation with no further writes.
- All outputs are registered except cmd_ready = (state == IDLE) & ~regen.
- FILL state:
  - Writes address fc = 0..32767 with write_en = 1 on 32768 consecutive cycles, starting the first cycle after rst deasserts.
  - write_addr = fc. write_data depends on y = fc[14:10]: y = 0 gives 1; y <= STONE_TOP gives 2; y <= DIRT_TOP gives 3; y == GRASS_Y gives 4; otherwise 0.
  - After fc = 32767 is written, the next cycle has state IDLE, init_done = 1 and write_en = 0.
- regen:
  - In IDLE: next cycle state is FILL and init_done = 0. The first fill write (addr 0) appears the cycle after that.
  - In FILL: the fill counter restarts at 0 and the sweep continues without a gap.
  - A regen pulse has priority over a simultaneous cmd_valid (cmd_ready is low that cycle).
- IDLE state:
  - A command accepted at edge N produces write_en/write_addr/write_data valid in cycle N+1 (latency 1).
  - Back-to-back commands are accepted every cycle.
  - write_addr = {cmd_y, cmd_z, cmd_x}.
  - write_data = cmd_place ? cmd_id : 0. Placing id 0 behaves as a break.
- Rejections (handshake still completes; write_en stays 0; cmd_err = 1 in cycle N+1):
  - break with cmd_y == 0 (bedrock floor is protected);
  - place with cmd_id > MAX_ID.
- Placing at y == 0 is allowed.
- edit_count:
  - Increments on each successful edit write and saturates at 16'hFFFF.
  - Cleared only by rst; unaffected by regen or fill writes.
- cmd_err and write_en are never both 1 for the same command.

Test Plan:
- Reset, then run -> exactly 32768 writes on consecutive cycles. addr 0 gets 1; addr 0x0400 (y=1) gets 2; y=21 gets 3; y=24 gets 4; addr 32767 gets 0. init_done rises the cycle after addr 32767; cmd_ready is 0 throughout the fill.
- In IDLE, place x=3, y=30, z=7, id=9 -> next cycle write_en=1, write_addr=15'h78E3, write_data=9, edit_count=1. Then break at the same coordinates -> write_data=0, edit_count=2.
- Break at y=0, and place id=20 -> cmd_err pulses once for each, no write_en, edit_count unchanged. Place id=1 at y=0 -> write succeeds.
- Issue regen at fill address 1000 -> the following write is addr 0 and the sweep completes 32768 writes from there. regen together with cmd_valid in IDLE -> cmd_ready=0 and the command is not written.
- Stream 3 commands back-to-back with cmd_valid held -> 3 consecutive write_en cycles, each with latency 1 and the correct addresses.
- Assert rst mid-fill and after 0xFFFF edits (force or long run) -> all outputs 0 next cycle. edit_count saturates at 0xFFFF before reset.
